// File: rtl/bus_burst_ram_if.sv
// Burst bus between a master and the burst RAM slave.
// Master drives: s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable.
// Slave drives:  s_waitrequest, s_readdata, s_readdatavalid.
interface bus_burst_ram_if;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned BCNT_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic [ADDR_W-1:0] s_address;
    logic [BCNT_W-1:0] s_burstcount;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;

    modport master (
        output s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport slave (
        input  s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface

// File: rtl/bus_burst_ram.sv
// Burst-capable single-port RAM slave, one outstanding burst at a time.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   s      - bus_burst_ram_if.slave (address/burstcount/read/write/writedata/
//            byteenable in; waitrequest/readdata/readdatavalid out)
//   err    - sticky out-of-range flag
// Optional build macro BUS_RAM_ADDR_CHECK_EN: flag beats whose unwrapped
// address exceeds the RAM, drop those writes and return 32'hDEADBEEF on reads.
// Without it beat addresses wrap modulo the RAM depth and err is tied low.
module bus_burst_ram #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_burst_ram_if.slave s,
    output logic           err
);
    localparam int unsigned ADDR_W    = 30;
    localparam int unsigned BCNT_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned MAX_BURST = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR       = 2'd1;
    localparam logic [1:0] ST_RD_FETCH = 2'd2;
    localparam logic [1:0] ST_RD_DATA  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BCNT_W-1:0] count_q, count_d;   // beats in current burst, 1..16
    logic [BCNT_W-1:0] idx_q, idx_d;       // next beat to write / fetch
    logic              rdv_q, rdv_d;
    logic              wait_q, wait_d;
    logic [DATA_W-1:0] rdata_q;

    logic [BCNT_W-1:0]     bcnt_clamped_c;
    logic [ADDR_W-1:0]     beat_base_c;
    logic [BCNT_W-1:0]     beat_idx_c;
    logic [ADDR_W:0]       beat_addr_c;    // unwrapped beat address
    logic [DEPTH_LOG2-1:0] mem_addr_c;
    logic                  beat_oob_c;
    logic                  mem_we_c;       // write beat requested this cycle
    logic                  mem_re_c;       // read fetch requested this cycle
    logic                  mem_wr_c;       // write actually committed

    logic [DATA_W-1:0] mem [DEPTH];

    // Burst length clamp: 0 means 1, anything above 16 means 16
    always_comb begin
        if (s.s_burstcount == '0) begin
            bcnt_clamped_c = BCNT_W'(1);
        end else if (s.s_burstcount > BCNT_W'(MAX_BURST)) begin
            bcnt_clamped_c = BCNT_W'(MAX_BURST);
        end else begin
            bcnt_clamped_c = s.s_burstcount;
        end
    end

    // Next-state, burst bookkeeping and RAM access requests
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        beat_base_c = base_q;
        beat_idx_c  = idx_q;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                beat_base_c = s.s_address;
                beat_idx_c  = '0;
                if (s.s_write) begin
                    // beat 0 is written in the accepting cycle
                    mem_we_c = 1'b1;
                    base_d   = s.s_address;
                    count_d  = bcnt_clamped_c;
                    idx_d    = BCNT_W'(1);
                    if (bcnt_clamped_c > BCNT_W'(1)) begin
                        state_d = ST_WR;
                    end
                end else if (s.s_read) begin
                    base_d  = s.s_address;
                    count_d = bcnt_clamped_c;
                    idx_d   = '0;
                    state_d = ST_RD_FETCH;
                end
            end
            ST_WR: begin
                if (s.s_write) begin
                    mem_we_c = 1'b1;
                    idx_d    = idx_q + BCNT_W'(1);
                    if (idx_q + BCNT_W'(1) == count_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_FETCH: begin
                mem_re_c = 1'b1;
                idx_d    = idx_q + BCNT_W'(1);
                state_d  = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // idx_q beats already fetched; fetch the next one while presenting this one
                if (idx_q < count_q) begin
                    mem_re_c = 1'b1;
                    idx_d    = idx_q + BCNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rdv_d  = mem_re_c;
        wait_d = (state_d == ST_RD_FETCH);
    end

    assign beat_addr_c = {1'b0, beat_base_c} + (ADDR_W+1)'(beat_idx_c);
    assign mem_addr_c  = beat_addr_c[DEPTH_LOG2-1:0];

`ifdef BUS_RAM_ADDR_CHECK_EN
    logic err_q;

    assign beat_oob_c = (beat_addr_c >> DEPTH_LOG2) != '0;

    // Sticky range error, raised by any accessed beat past the top of RAM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((mem_we_c || mem_re_c) && beat_oob_c) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_c;

    assign beat_oob_c = 1'b0;
    assign unused_c   = ^beat_addr_c[ADDR_W:DEPTH_LOG2];
    assign err        = 1'b0;
`endif

    // Reset aborts the burst: no write commits on a reset edge
    assign mem_wr_c = mem_we_c && !beat_oob_c && rst_n;

    // State and burst registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            rdv_q   <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            rdv_q   <= rdv_d;
            wait_q  <= wait_d;
        end
    end

    // RAM array with byte-enable write port; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (s.s_byteenable[i]) begin
                    mem[mem_addr_c][8*i +: 8] <= s.s_writedata[8*i +: 8];
                end
            end
        end
    end

    // RAM output register doubles as s_readdata; held at zero between beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (mem_re_c) begin
            rdata_q <= beat_oob_c ? DATA_W'(32'hDEADBEEF) : mem[mem_addr_c];
        end else begin
            rdata_q <= '0;
        end
    end

    assign s.s_waitrequest   = wait_q;
    assign s.s_readdatavalid = rdv_q;
    assign s.s_readdata      = rdata_q;
endmodule
